// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the auto-baud UART link. Both the transmitter
// and the auto-baud receiver import this package so that they agree on
// the frame layout and the sync character.
//   state_t       : transmit/receive frame FSM states
//   SYNC_CHAR     : alternating-bit sync byte the far end locks onto
//   FRAME_BITS    : start + 8 data + stop
//   DIV_W_DEFAULT : default width of the bit-period divisor
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   localparam logic [7:0] SYNC_CHAR     = 8'h55;
   localparam int         FRAME_BITS    = 10;
   localparam int         DIV_W_DEFAULT = 8;

endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen
// Produces a one-cycle tick every N+1 clock cycles. A load pulse restarts
// the period so that the first tick after frame acceptance lands exactly
// N cycles after the load edge.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   N    : bit period minus one, in clock cycles
//   load : restart the period (count returns to zero)
//   tick : high during the last cycle of each bit period
module baud_tick_gen
   import uart_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] N,
   input  logic             load,
   output logic             tick
);

   logic [DIV_W-1:0] count;

   // The count never passes N, so N at its maximum still fits in DIV_W
   // bits and simply gives a 2**DIV_W cycle period.
   always_ff @(posedge clk) begin
      if (rst || load) begin
         count <= '0;
      end else if (count == N) begin
         count <= '0;
      end else begin
         count <= count + DIV_W'(1);
      end
   end

   assign tick = (count == N);

endmodule

// File: rtl/uart_abaud_tx.sv
// uart_abaud_tx
// 8N1 transmitter for the auto-baud link. The bit period is N+1 clocks,
// with N latched when a byte is accepted. With sync_req set, the byte is
// preceded by a SYNC_CHAR frame with no idle gap in between, so the far
// end can measure the bit period before the real data arrives.
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   N        : bit period minus one, in clock cycles
//   tx_data  : byte to send
//   tx_valid : host offers tx_data
//   tx_ready : transmitter can accept a byte this cycle (IDLE only)
//   sync_req : prefix this byte with a sync frame
//   UxTX     : serial line, idle high, registered
//   busy     : a frame is currently on the line
//   done     : one-cycle pulse when the data frame's stop bit completes
module uart_abaud_tx
   import uart_pkg::*;
#(
   parameter int         DIV_W     = DIV_W_DEFAULT,
   parameter logic [7:0] SYNC_CHAR = uart_pkg::SYNC_CHAR
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] N,
   input  logic [7:0]       tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   input  logic             sync_req,
   output logic             UxTX,
   output logic             busy,
   output logic             done
);

   state_t           state;
   logic [DIV_W-1:0] n_lat;
   logic [7:0]       data_lat;
   logic [7:0]       shreg;
   logic [2:0]       bit_idx;
   logic             sync_pending;
   logic             accept;
   logic             tick;

   assign tx_ready = (state == IDLE);
   assign accept   = tx_ready && tx_valid;

   baud_tick_gen #(
      .DIV_W (DIV_W)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .N    (n_lat),
      .load (accept),
      .tick (tick)
   );

   // Frame FSM. The line, busy and done registers are all driven from
   // the current state, so the waveform on UxTX trails the state register
   // by one cycle. That puts the first IDLE cycle on top of the final stop
   // cycle, so a back-to-back byte costs only one extra high cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         n_lat        <= '0;
         data_lat     <= '0;
         shreg        <= '0;
         bit_idx      <= '0;
         sync_pending <= 1'b0;
         UxTX         <= 1'b1;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         done <= 1'b0;
         busy <= (state != IDLE);

         case (state)
            START:   UxTX <= 1'b0;
            DATA:    UxTX <= shreg[0];
            default: UxTX <= 1'b1;
         endcase

         case (state)
            IDLE: begin
               if (tx_valid) begin
                  n_lat        <= N;
                  data_lat     <= tx_data;
                  sync_pending <= sync_req;
                  shreg        <= sync_req ? SYNC_CHAR : tx_data;
                  bit_idx      <= '0;
                  state        <= START;
               end
            end
            START: begin
               if (tick) begin
                  state <= DATA;
               end
            end
            DATA: begin
               if (tick) begin
                  shreg <= {1'b0, shreg[7:1]};
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  if (sync_pending) begin
                     sync_pending <= 1'b0;
                     shreg        <= data_lat;
                     bit_idx      <= '0;
                     state        <= START;
                  end else begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
